alu_issue_rs: RTL and testbench
===============================

Name: alu_issue_rs

Overview:
- Reservation station and issue scheduler in front of the integer ALU.
- Holds up to ENTRIES dispatched ALU micro-ops and captures operand values from the common data bus (CDB) as they arrive.
- Each cycle, selects the oldest entry with both operands ready and drives it onto the ALU's op/value_1/value_2/des/is_branch inputs.
- ROB tag 0 means "no tag / nothing"; the ALU treats des 0 as an idle slot.

Parameters:
- ENTRIES, 4, number of station entries (2..8).
- TAG_W, 3, ROB tag width. Tag 0 is reserved as "operand already valid / no destination".

Ports:
- clk  input  1  system clock, posedge-active.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  branch-mispredict flush; clears all entries.
- disp_valid  input  1  dispatch request.
- disp_ready  output  1  station can accept a dispatch; equals !full (combinational).
- disp_op  input  5  ALU opcode.
- disp_is_branch  input  1  op is a branch compare.
- disp_des  input  TAG_W  destination ROB tag (nonzero).
- disp_v1  input  32  operand 1 value; valid when disp_q1 is 0.
- disp_q1  input  TAG_W  operand 1 producer tag; 0 means ready.
- disp_v2  input  32  operand 2 value.
- disp_q2  input  TAG_W  operand 2 producer tag.
- cdb_valid  input  1  CDB broadcast valid.
- cdb_tag  input  TAG_W  broadcast ROB tag.
- cdb_value  input  32  broadcast result.
- issue_op  output  5  to ALU op.
- issue_v1  output  32  to ALU value_1.
- issue_v2  output  32  to ALU value_2.
- issue_des  output  TAG_W  to ALU des_input; 0 when idle.
- issue_is_branch  output  1  to ALU is_branch_input.
- count  output  clog2(ENTRIES)+1  number of occupied entries.

Behaviour:
- Reset (async): all entry valid bits, the age matrix, all issue_* outputs and count go to 0. disp_ready is 1 after reset.
- Entry fields: valid, op, is_branch, des, v1, q1, v2, q2.
- Allocation: a dispatch is accepted when disp_valid && disp_ready && !flush. It writes the lowest-index free entry.
- Dispatch-time capture: if cdb_valid and cdb_tag equals a nonzero disp_qN in the same cycle, store cdb_value as the operand and set qN to 0.
- Wakeup: every edge, each valid entry whose qN is nonzero and matches cdb_tag (with cdb_valid) loads cdb_value and clears qN.
- Ready condition: valid && q1==0 && q2==0, evaluated on registered state. There is no same-cycle CDB bypass (see Optional Feature).
- Select policy: oldest ready entry first, using an ENTRIES x ENTRIES age matrix.
  - On allocation of entry i, row i is set to "older than" every other currently valid entry.
  - Issue or flush clears the entry's bits.
- Issue: one entry per cycle. Outputs are registered, so the selected entry appears on issue_* after the edge and its valid bit clears on that same edge.
- Idle cycle: issue_des=0, issue_op=0, issue_v1=0, issue_v2=0, issue_is_branch=0.
- Latency: a dispatch with both operands ready at edge N is visible on issue_* after edge N+1. A CDB wakeup at edge N allows issue after edge N+1.
- Full: no dispatch is accepted. An issue in the same cycle does not free a slot for that cycle's dispatch.
- Empty: the station produces idle output.
- Flush: synchronous and highest priority.
  - Clears all entries and the age matrix.
  - Sets issue_* to idle on the next edge.
  - Ignores that cycle's dispatch and CDB.
- Reset mid-operation: entries discarded immediately; outputs go idle asynchronously.
- Simultaneous dispatch, wakeup and issue on different entries all take effect on the same edge.
- count updates by +1, -1 or 0 accordingly.

Optional Feature:
- Macro ALU_ISSUE_RS_BYPASS_EN.
- Defined: an entry whose only missing operand(s) match the current cdb_tag counts as ready this cycle. It issues with cdb_value muxed into the operand, saving one cycle of wakeup-to-issue latency.
- Not defined: wakeup-to-issue is the one-cycle path described above. No combinational path exists from cdb_* to issue selection.

Test Plan:
- Reset, then dispatch op=ADD(0), des=3, v1=5, v2=7, q1=q2=0 -> after the next edge issue_des=3, issue_v1=5, issue_v2=7. The cycle after that, issue_des=0.
- Dispatch des=2 with q1=5, then 3 cycles later CDB tag=5 value=0x10 -> issue_des=2, issue_v1=0x10 one edge after the CDB (same edge when bypass is enabled).
- Fill 4 entries with q1=6 (des 1..4), then assert a 5th dispatch -> disp_ready=0 and count=4. CDB tag=6 -> des 1,2,3,4 issue in dispatch order on consecutive cycles.
- Dispatch with disp_q2=4 while CDB tag=4 value=0xABCD is in the same cycle -> entry stores 0xABCD and issues on the next edge with issue_v2=0xABCD.
- With 3 entries valid, assert flush together with a dispatch -> count=0, issue_des=0 next edge, dispatched op never issues.
- Assert rst asynchronously between edges while issue_des=5 -> issue_des drops to 0 immediately, count=0, disp_ready=1.

Source files
------------

// File: rtl/alu_issue_rs.sv
// alu_issue_rs -- reservation station and issue scheduler for the integer ALU.
//
// Holds up to ENTRIES dispatched ALU micro-ops, captures missing operands
// from the common data bus (CDB), and each cycle issues the oldest entry whose
// operands are both ready onto registered issue_* outputs. ROB tag 0 means
// "no tag": a zero operand tag marks the value as present, and issue_des = 0
// marks an idle issue slot.
//
// Parameters:
//   ENTRIES  number of station entries (2..8)
//   TAG_W    ROB tag width
//
// Ports:
//   clk, rst            clock (posedge) and asynchronous active-high reset
//   flush               synchronous clear of every entry; overrides dispatch/CDB
//   disp_*              dispatch request/payload; disp_ready = station not full
//   cdb_valid/tag/value result broadcast used for operand capture and wakeup
//   issue_*             registered micro-op presented to the ALU (all 0 = idle)
//   count               number of occupied entries
//
// Build option:
//   ALU_ISSUE_RS_BYPASS_EN  when defined, an entry whose only missing operands
//                           match the current CDB tag issues in that same cycle
//                           with cdb_value forwarded into the operand.
module alu_issue_rs #(
   parameter int ENTRIES = 4,
   parameter int TAG_W   = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       disp_valid,
   output logic                       disp_ready,
   input  logic [4:0]                 disp_op,
   input  logic                       disp_is_branch,
   input  logic [TAG_W-1:0]           disp_des,
   input  logic [31:0]                disp_v1,
   input  logic [TAG_W-1:0]           disp_q1,
   input  logic [31:0]                disp_v2,
   input  logic [TAG_W-1:0]           disp_q2,
   input  logic                       cdb_valid,
   input  logic [TAG_W-1:0]           cdb_tag,
   input  logic [31:0]                cdb_value,
   output logic [4:0]                 issue_op,
   output logic [31:0]                issue_v1,
   output logic [31:0]                issue_v2,
   output logic [TAG_W-1:0]           issue_des,
   output logic                       issue_is_branch,
   output logic [$clog2(ENTRIES):0]   count
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int CNT_W = $clog2(ENTRIES) + 1;

   logic [ENTRIES-1:0] valid;
   logic [4:0]         e_op  [ENTRIES];
   logic               e_br  [ENTRIES];
   logic [TAG_W-1:0]   e_des [ENTRIES];
   logic [31:0]        e_v1  [ENTRIES];
   logic [31:0]        e_v2  [ENTRIES];
   logic [TAG_W-1:0]   e_q1  [ENTRIES];
   logic [TAG_W-1:0]   e_q2  [ENTRIES];
   // age[i][j] = 1 means entry j is older than entry i
   logic [ENTRIES-1:0] age   [ENTRIES];

   logic [ENTRIES-1:0] rdy;
   logic [ENTRIES-1:0] sel_oh;
   logic [31:0]        op1   [ENTRIES];
   logic [31:0]        op2   [ENTRIES];
   logic               sel_any;
   logic [IDX_W-1:0]   sel_idx;
   logic [IDX_W-1:0]   alloc_idx;
   logic               free_found;
   logic               full;
   logic               alloc;
   logic               d_hit1;
   logic               d_hit2;

   always_comb begin
      rdy = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         op1[i] = e_v1[i];
         op2[i] = e_v2[i];
`ifdef ALU_ISSUE_RS_BYPASS_EN
         if (cdb_valid && e_q1[i] != '0 && e_q1[i] == cdb_tag) op1[i] = cdb_value;
         if (cdb_valid && e_q2[i] != '0 && e_q2[i] == cdb_tag) op2[i] = cdb_value;
         rdy[i] = valid[i]
                  && (e_q1[i] == '0 || (cdb_valid && e_q1[i] == cdb_tag))
                  && (e_q2[i] == '0 || (cdb_valid && e_q2[i] == cdb_tag));
`else
         rdy[i] = valid[i] && e_q1[i] == '0 && e_q2[i] == '0;
`endif
      end

      // An entry is the oldest ready one when no ready entry is older than it.
      sel_oh  = '0;
      sel_any = 1'b0;
      sel_idx = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (rdy[i] && (age[i] & rdy) == '0) begin
            sel_oh[i] = 1'b1;
            sel_any   = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end

      alloc_idx  = '0;
      free_found = 1'b0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (!valid[i] && !free_found) begin
            alloc_idx  = IDX_W'(i);
            free_found = 1'b1;
         end
      end

      full   = &valid;
      alloc  = disp_valid && !full && !flush;
      d_hit1 = cdb_valid && disp_q1 != '0 && disp_q1 == cdb_tag;
      d_hit2 = cdb_valid && disp_q2 != '0 && disp_q2 == cdb_tag;
   end

   assign disp_ready = !full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid           <= '0;
         count           <= '0;
         issue_op        <= '0;
         issue_v1        <= '0;
         issue_v2        <= '0;
         issue_des       <= '0;
         issue_is_branch <= 1'b0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            age[i]   <= '0;
            e_op[i]  <= '0;
            e_br[i]  <= 1'b0;
            e_des[i] <= '0;
            e_v1[i]  <= '0;
            e_v2[i]  <= '0;
            e_q1[i]  <= '0;
            e_q2[i]  <= '0;
         end
      end else if (flush) begin
         valid           <= '0;
         count           <= '0;
         issue_op        <= '0;
         issue_v1        <= '0;
         issue_v2        <= '0;
         issue_des       <= '0;
         issue_is_branch <= 1'b0;
         for (int unsigned i = 0; i < ENTRIES; i++) age[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (alloc && alloc_idx == IDX_W'(i)) begin
               valid[i] <= 1'b1;
               e_op[i]  <= disp_op;
               e_br[i]  <= disp_is_branch;
               e_des[i] <= disp_des;
               e_v1[i]  <= d_hit1 ? cdb_value : disp_v1;
               e_q1[i]  <= d_hit1 ? '0 : disp_q1;
               e_v2[i]  <= d_hit2 ? cdb_value : disp_v2;
               e_q2[i]  <= d_hit2 ? '0 : disp_q2;
               // New entry is younger than everything staying in the station.
               age[i]   <= valid & ~sel_oh;
            end else begin
               if (sel_oh[i]) begin
                  valid[i] <= 1'b0;
                  age[i]   <= '0;
               end else begin
                  age[i]   <= age[i] & ~sel_oh;
               end
               if (valid[i] && cdb_valid && e_q1[i] != '0 && e_q1[i] == cdb_tag) begin
                  e_v1[i] <= cdb_value;
                  e_q1[i] <= '0;
               end
               if (valid[i] && cdb_valid && e_q2[i] != '0 && e_q2[i] == cdb_tag) begin
                  e_v2[i] <= cdb_value;
                  e_q2[i] <= '0;
               end
            end
         end

         if (sel_any) begin
            issue_op        <= e_op[sel_idx];
            issue_v1        <= op1[sel_idx];
            issue_v2        <= op2[sel_idx];
            issue_des       <= e_des[sel_idx];
            issue_is_branch <= e_br[sel_idx];
         end else begin
            issue_op        <= '0;
            issue_v1        <= '0;
            issue_v2        <= '0;
            issue_des       <= '0;
            issue_is_branch <= 1'b0;
         end

         case ({alloc, sel_any})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_rs.sv
module tb_alu_issue_rs;

   localparam int ENTRIES = 4;
   localparam int TAG_W   = 3;
`ifdef ALU_ISSUE_RS_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             disp_valid;
   logic             disp_ready;
   logic [4:0]       disp_op;
   logic             disp_is_branch;
   logic [TAG_W-1:0] disp_des;
   logic [31:0]      disp_v1;
   logic [TAG_W-1:0] disp_q1;
   logic [31:0]      disp_v2;
   logic [TAG_W-1:0] disp_q2;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [31:0]      cdb_value;
   logic [4:0]       issue_op;
   logic [31:0]      issue_v1;
   logic [31:0]      issue_v2;
   logic [TAG_W-1:0] issue_des;
   logic             issue_is_branch;
   logic [2:0]       count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_issue_rs #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
      .disp_is_branch(disp_is_branch), .disp_des(disp_des),
      .disp_v1(disp_v1), .disp_q1(disp_q1), .disp_v2(disp_v2), .disp_q2(disp_q2),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .issue_op(issue_op), .issue_v1(issue_v1), .issue_v2(issue_v2),
      .issue_des(issue_des), .issue_is_branch(issue_is_branch), .count(count)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      flush = 1'b0; disp_valid = 1'b0; disp_op = '0; disp_is_branch = 1'b0;
      disp_des = '0; disp_v1 = '0; disp_q1 = '0; disp_v2 = '0; disp_q2 = '0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
   endtask

   task automatic put_disp(input logic [4:0] op, input logic br, input logic [2:0] des,
                           input logic [31:0] v1, input logic [2:0] q1,
                           input logic [31:0] v2, input logic [2:0] q2);
      disp_valid = 1'b1; disp_op = op; disp_is_branch = br; disp_des = des;
      disp_v1 = v1; disp_q1 = q1; disp_v2 = v2; disp_q2 = q2;
   endtask

   task automatic put_cdb(input logic [2:0] tag, input logic [31:0] value);
      cdb_valid = 1'b1; cdb_tag = tag; cdb_value = value;
   endtask

   task automatic test_reset;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (issue_des !== 3'd0) begin errors++; $display("FAIL reset_des: got %0d expected 0", issue_des); end
      checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", disp_ready); end
      checks++; if (issue_v1 !== 32'd0) begin errors++; $display("FAIL reset_v1: got %0h expected 0", issue_v1); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_issue;
      put_disp(5'd0, 1'b0, 3'd3, 32'd5, 3'd0, 32'd7, 3'd0);
      tick();
      idle_inputs();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL basic_count1: got %0d expected 1", count); end
      checks++; if (issue_des !== 3'd0) begin errors++; $display("FAIL basic_early: got %0d expected 0", issue_des); end
      tick();
      checks++; if (issue_des !== 3'd3) begin errors++; $display("FAIL basic_des: got %0d expected 3", issue_des); end
      checks++; if (issue_v1 !== 32'd5) begin errors++; $display("FAIL basic_v1: got %0h expected 5", issue_v1); end
      checks++; if (issue_v2 !== 32'd7) begin errors++; $display("FAIL basic_v2: got %0h expected 7", issue_v2); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_count0: got %0d expected 0", count); end
      tick();
      checks++; if (issue_des !== 3'd0) begin errors++; $display("FAIL basic_idle: got %0d expected 0", issue_des); end
      checks++; if (issue_v1 !== 32'd0) begin errors++; $display("FAIL basic_idle_v1: got %0h expected 0", issue_v1); end
   endtask

   task automatic test_back_to_back;
      put_disp(5'd1, 1'b0, 3'd1, 32'd1, 3'd0, 32'd0, 3'd0);
      tick();
      put_disp(5'd1, 1'b0, 3'd2, 32'd2, 3'd0, 32'd0, 3'd0);
      tick();
      checks++; if (issue_des !== 3'd1) begin errors++; $display("FAIL b2b_1: got %0d expected 1", issue_des); end
      put_disp(5'd1, 1'b0, 3'd3, 32'd3, 3'd0, 32'd0, 3'd0);
      tick();
      checks++; if (issue_des !== 3'd2) begin errors++; $display("FAIL b2b_2: got %0d expected 2", issue_des); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count: got %0d expected 1", count); end
      idle_inputs();
      tick();
      checks++; if (issue_des !== 3'd3) begin errors++; $display("FAIL b2b_3: got %0d expected 3", issue_des); end
      checks++; if (issue_v1 !== 32'd3) begin errors++; $display("FAIL b2b_v1: got %0h expected 3", issue_v1); end
      tick();
      checks++; if (issue_des !== 3'd0) begin errors++; $display("FAIL b2b_idle: got %0d expected 0", issue_des); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_count0: got %0d expected 0", count); end
   endtask

   task automatic test_wakeup;
      put_disp(5'd0, 1'b0, 3'd2, 32'd0, 3'd5, 32'd3, 3'd0);
      tick();
      idle_inputs();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL wake_count: got %0d expected 1", count); end
      tick();
      checks++; if (issue_des !== 3'd0) begin errors++; $display("FAIL wake_wait1: got %0d expected 0", issue_des); end
      tick();
      checks++; if (issue_des !== 3'd0) begin errors++; $display("FAIL wake_wait2: got %0d expected 0", issue_des); end
      put_cdb(3'd5, 32'h10);
      tick();
      idle_inputs();
      checks++; if (issue_des !== (BYP ? 3'd2 : 3'd0)) begin errors++; $display("FAIL wake_cdb_edge: got %0d expected %0d", issue_des, BYP ? 2 : 0); end
      checks++; if (issue_v1 !== (BYP ? 32'h10 : 32'h0)) begin errors++; $display("FAIL wake_cdb_edge_v1: got %0h expected %0h", issue_v1, BYP ? 32'h10 : 32'h0); end
      tick();
      checks++; if (issue_des !== (BYP ? 3'd0 : 3'd2)) begin errors++; $display("FAIL wake_issue: got %0d expected %0d", issue_des, BYP ? 0 : 2); end
      checks++; if (issue_v1 !== (BYP ? 32'h0 : 32'h10)) begin errors++; $display("FAIL wake_v1: got %0h expected %0h", issue_v1, BYP ? 32'h0 : 32'h10); end
      checks++; if (issue_v2 !== (BYP ? 32'h0 : 32'h3)) begin errors++; $display("FAIL wake_v2: got %0h expected %0h", issue_v2, BYP ? 32'h0 : 32'h3); end
   endtask

   task automatic test_full_and_order;
      logic [2:0] exp_seq [6];
      for (int d = 1; d <= 4; d++) begin
         put_disp(5'd2, 1'b0, 3'(d), 32'd0, 3'd6, 32'(d), 3'd0);
         tick();
      end
      idle_inputs();
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
      checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b expected 0", disp_ready); end
      put_disp(5'd2, 1'b0, 3'd7, 32'h77, 3'd0, 32'h77, 3'd0);
      tick();
      idle_inputs();
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_reject_count: got %0d expected 4", count); end
      checks++; if (issue_des !== 3'd0) begin errors++; $display("FAIL full_reject_des: got %0d expected 0", issue_des); end
      put_cdb(3'd6, 32'h66);
      tick();
      idle_inputs();
      if (BYP) begin
         exp_seq[0] = 3'd1; exp_seq[1] = 3'd2; exp_seq[2] = 3'd3;
         exp_seq[3] = 3'd4; exp_seq[4] = 3'd0; exp_seq[5] = 3'd0;
      end else begin
         exp_seq[0] = 3'd0; exp_seq[1] = 3'd1; exp_seq[2] = 3'd2;
         exp_seq[3] = 3'd3; exp_seq[4] = 3'd4; exp_seq[5] = 3'd0;
      end
      for (int k = 0; k < 6; k++) begin
         checks++; if (issue_des !== exp_seq[k]) begin errors++; $display("FAIL order_des[%0d]: got %0d expected %0d", k, issue_des, exp_seq[k]); end
         checks++; if (issue_v1 !== ((exp_seq[k] != 3'd0) ? 32'h66 : 32'h0)) begin errors++; $display("FAIL order_v1[%0d]: got %0h", k, issue_v1); end
         checks++; if (issue_v2 !== 32'(exp_seq[k])) begin errors++; $display("FAIL order_v2[%0d]: got %0h expected %0h", k, issue_v2, exp_seq[k]); end
         if (k < 5) tick();
      end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL order_count: got %0d expected 0", count); end
   endtask

   task automatic test_capture;
      put_disp(5'd9, 1'b1, 3'd5, 32'h11, 3'd0, 32'h0, 3'd4);
      put_cdb(3'd4, 32'hABCD);
      tick();
      idle_inputs();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL cap_count: got %0d expected 1", count); end
      tick();
      checks++; if (issue_des !== 3'd5) begin errors++; $display("FAIL cap_des: got %0d expected 5", issue_des); end
      checks++; if (issue_v2 !== 32'hABCD) begin errors++; $display("FAIL cap_v2: got %0h expected abcd", issue_v2); end
      checks++; if (issue_v1 !== 32'h11) begin errors++; $display("FAIL cap_v1: got %0h expected 11", issue_v1); end
      checks++; if (issue_op !== 5'd9) begin errors++; $display("FAIL cap_op: got %0d expected 9", issue_op); end
      checks++; if (issue_is_branch !== 1'b1) begin errors++; $display("FAIL cap_br: got %0b expected 1", issue_is_branch); end
      tick();
      checks++; if (issue_des !== 3'd0) begin errors++; $display("FAIL cap_idle_des: got %0d expected 0", issue_des); end
      checks++; if (issue_op !== 5'd0) begin errors++; $display("FAIL cap_idle_op: got %0d expected 0", issue_op); end
      checks++; if (issue_is_branch !== 1'b0) begin errors++; $display("FAIL cap_idle_br: got %0b expected 0", issue_is_branch); end
   endtask

   task automatic test_flush;
      put_disp(5'd0, 1'b0, 3'd1, 32'd0, 3'd7, 32'd0, 3'd0);
      tick();
      put_disp(5'd0, 1'b0, 3'd2, 32'd0, 3'd7, 32'd0, 3'd0);
      tick();
      put_disp(5'd3, 1'b0, 3'd3, 32'h33, 3'd0, 32'd0, 3'd0);
      tick();
      idle_inputs();
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
      flush = 1'b1;
      put_disp(5'd4, 1'b0, 3'd4, 32'h44, 3'd0, 32'h44, 3'd0);
      put_cdb(3'd7, 32'h70);
      tick();
      idle_inputs();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
      checks++; if (issue_des !== 3'd0) begin errors++; $display("FAIL flush_des: got %0d expected 0", issue_des); end
      checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0b expected 1", disp_ready); end
      tick();
      checks++; if (issue_des !== 3'd0) begin errors++; $display("FAIL flush_no_disp: got %0d expected 0", issue_des); end
      put_cdb(3'd7, 32'h71);
      tick();
      idle_inputs();
      tick();
      checks++; if (issue_des !== 3'd0) begin errors++; $display("FAIL flush_no_wake: got %0d expected 0", issue_des); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count_end: got %0d expected 0", count); end
   endtask

   task automatic test_async_reset;
      put_disp(5'd0, 1'b0, 3'd1, 32'd0, 3'd3, 32'd0, 3'd0);
      tick();
      put_disp(5'd0, 1'b0, 3'd5, 32'h55, 3'd0, 32'h56, 3'd0);
      tick();
      idle_inputs();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL arst_pre_count: got %0d expected 2", count); end
      tick();
      checks++; if (issue_des !== 3'd5) begin errors++; $display("FAIL arst_pre_des: got %0d expected 5", issue_des); end
      #2 rst = 1'b1;
      #1;
      checks++; if (issue_des !== 3'd0) begin errors++; $display("FAIL arst_des: got %0d expected 0", issue_des); end
      checks++; if (issue_v1 !== 32'd0) begin errors++; $display("FAIL arst_v1: got %0h expected 0", issue_v1); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", count); end
      checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %0b expected 1", disp_ready); end
      #1 rst = 1'b0;
      put_cdb(3'd3, 32'h99);
      tick();
      idle_inputs();
      tick();
      checks++; if (issue_des !== 3'd0) begin errors++; $display("FAIL arst_discard: got %0d expected 0", issue_des); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL arst_count_end: got %0d expected 0", count); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      test_reset();
      test_basic_issue();
      test_back_to_back();
      test_wakeup();
      test_full_and_order();
      test_capture();
      test_flush();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
